// File: rtl/aftab_trap_pkg.sv
// Shared constants for the AFTAB trap sequencer: privilege encodings, FSM
// states, interrupt priority order and tval source causes.
package aftab_trap_pkg;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_M = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } trapState_t;

  // Entry 5 is the highest priority; 16 and up follow everything listed here.
  localparam int INT_PRIO_N = 6;
  localparam logic [INT_PRIO_N-1:0][3:0] INT_PRIO =
    {4'd11, 4'd3, 4'd7, 4'd8, 4'd0, 4'd4};

  localparam logic [15:0] USER_LINE_MASK = 16'h0111;
  localparam logic [15:0] M_LINE_MASK    = 16'h0888;

  localparam int TVAL_CAUSE_PC   = 32'd0;
  localparam int TVAL_CAUSE_INST = 32'd2;
  localparam int TVAL_CAUSE_LADR = 32'd4;
  localparam int TVAL_CAUSE_SADR = 32'd6;

endpackage

// File: rtl/aftab_trap_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module aftab_trap_prio_enc #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      idx   = vec[i] ? IW'(i) : idx;
      valid = valid | vec[i];
    end
  end

endmodule

// File: rtl/aftab_trap_sequencer.sv
// Selects the highest-priority trap, registers it for the control unit via
// req/ack, and tracks current/previous privilege plus a taken-trap count.
module aftab_trap_sequencer
  import aftab_trap_pkg::*;
#(
  parameter int len     = 32,
  parameter int NUM_EXC = 12,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_EXC-1:0] excFlags,
  input  logic               instrBoundary,
  input  logic [len-1:0]     inst,
  input  logic [len-1:0]     outPC,
  input  logic [len-1:0]     outADR,
  input  logic [len-1:0]     mipCC,
  input  logic [len-1:0]     mieCC,
  input  logic [len-1:0]     midelegCSR,
  input  logic [len-1:0]     medelegCSR,
  input  logic               mieFieldCC,
  input  logic               uieFieldCC,
  input  logic               trapAck,
  input  logic               mret,
  input  logic               uret,
  output logic               trapReq,
  output logic [len-1:0]     causeCode,
  output logic [len-1:0]     trapValue,
  output logic [1:0]         targetPRV,
  output logic [1:0]         curPRV,
  output logic [1:0]         prevPRV,
  output logic [CNT_W-1:0]   trapCount
);

  localparam int EW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
  localparam int LW = $clog2(len);
  localparam int RN = len - 16;
  localparam int RW = (RN > 1) ? $clog2(RN) : 1;

  trapState_t      state_r;
  logic [EW-1:0]   excIdx_s;
  logic            excValid_s;
  logic [RW-1:0]   resIdx_s;
  logic            resValid_s;
  logic [len-1:0]  pend_s;
  logic            mEnable_s;
  logic            uEnable_s;
  logic [15:0]     qualLow_s;
  logic [RN-1:0]   qualRes_s;
  logic [LW-1:0]   intLine_s;
  logic            intValid_s;
  logic            delegBit_s;
  logic [len-1:0]  causeNext_s;
  logic [len-1:0]  tvalNext_s;
  logic [1:0]      targetNext_s;

  assign pend_s    = mipCC & mieCC & {len{instrBoundary}};
  assign mEnable_s = (curPRV == PRV_U) | ((curPRV == PRV_M) & mieFieldCC);
  assign uEnable_s = (curPRV == PRV_U) & uieFieldCC;
  assign qualLow_s = pend_s[15:0] & ((M_LINE_MASK & {16{mEnable_s}}) |
                                     (USER_LINE_MASK & {16{uEnable_s}}));
  assign qualRes_s = pend_s[len-1:16] & {RN{mEnable_s}};

  aftab_trap_prio_enc #(.W(NUM_EXC), .IW(EW)) excEnc (
    .vec   (excFlags),
    .idx   (excIdx_s),
    .valid (excValid_s)
  );

  aftab_trap_prio_enc #(.W(RN), .IW(RW)) resEnc (
    .vec   (qualRes_s),
    .idx   (resIdx_s),
    .valid (resValid_s)
  );

  // Interrupt line pick: reserved field first, then listed lines override in rising priority.
  always_comb begin
    intValid_s = resValid_s;
    intLine_s  = resValid_s ? (LW'(resIdx_s) + LW'(16)) : '0;
    for (int k = 0; k < INT_PRIO_N; k++) begin
      intLine_s  = qualLow_s[INT_PRIO[k]] ? LW'(INT_PRIO[k]) : intLine_s;
      intValid_s = intValid_s | qualLow_s[INT_PRIO[k]];
    end
  end

  // Cause, tval and handling mode for whichever trap wins this cycle.
  always_comb begin
    causeNext_s = '0;
    tvalNext_s  = '0;
    delegBit_s  = 1'b0;
    if (excValid_s) begin
      causeNext_s = len'(excIdx_s);
      delegBit_s  = medelegCSR[LW'(excIdx_s)];
      if (excIdx_s == EW'(TVAL_CAUSE_INST)) begin
        tvalNext_s = inst;
      end else if (excIdx_s == EW'(TVAL_CAUSE_PC)) begin
        tvalNext_s = outPC;
      end else if ((excIdx_s == EW'(TVAL_CAUSE_LADR)) ||
                   (excIdx_s == EW'(TVAL_CAUSE_SADR))) begin
        tvalNext_s = outADR;
      end else begin
        tvalNext_s = '0;
      end
    end else begin
      causeNext_s = {1'b1, (len-1)'(intLine_s)};
      delegBit_s  = midelegCSR[intLine_s];
    end
    targetNext_s = ((curPRV == PRV_U) && delegBit_s) ? PRV_U : PRV_M;
  end

  // Trap handshake FSM with privilege tracking and saturating trap counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      trapReq   <= 1'b0;
      causeCode <= '0;
      trapValue <= '0;
      targetPRV <= PRV_M;
      curPRV    <= PRV_M;
      prevPRV   <= PRV_M;
      trapCount <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (excValid_s || intValid_s) begin
            state_r   <= REQ;
            trapReq   <= 1'b1;
            causeCode <= causeNext_s;
            trapValue <= tvalNext_s;
            targetPRV <= targetNext_s;
          end else if (mret) begin
            curPRV  <= prevPRV;
            prevPRV <= PRV_U;
          end else if (uret) begin
            curPRV <= PRV_U;
          end
        end
        REQ: begin
          if (trapAck) begin
            state_r   <= IDLE;
            trapReq   <= 1'b0;
            prevPRV   <= curPRV;
            curPRV    <= targetPRV;
            trapCount <= (trapCount == {CNT_W{1'b1}}) ? trapCount
                                                      : trapCount + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          trapReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
